// File: rtl/odometer_multi_meas.sv
// Multi-channel odometer measurement sequencer.
// Sweeps NCH stress/reference ring-oscillator pairs. For each enabled channel
// it pauses stress, waits SETTLE cycles, then counts rising edges of both
// oscillators over a WINDOW-cycle window. Results are packed into a serially
// readable shift register.
//
// Ports:
//   MEAS_CLK, RESETB        clock, asynchronous active-low reset
//   MEAS_TRIG               sweep request (0->1 edge while idle)
//   CH_MASK, WINDOW         per-channel enable, counting window (0 acts as 1)
//   ROSC_STRESS_OUT/REF_OUT asynchronous oscillator outputs
//   SHIFT_EN, SCANOUT_DIN   result register shift control / serial input
//   MEAS_STRESS, EN_ROSC    one-hot active channel while busy
//   BUSY, DONE              sweep in progress, one-cycle end-of-sweep pulse
//   SCANOUT_DOUT            result register bit 0
module odometer_multi_meas #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CW     = 12,
    parameter int unsigned WIN_W  = 16,
    parameter int unsigned SETTLE = 8
) (
    input  logic             MEAS_CLK,
    input  logic             RESETB,
    input  logic             MEAS_TRIG,
    input  logic [NCH-1:0]   CH_MASK,
    input  logic [WIN_W-1:0] WINDOW,
    input  logic [NCH-1:0]   ROSC_STRESS_OUT,
    input  logic [NCH-1:0]   ROSC_REF_OUT,
    input  logic             SHIFT_EN,
    input  logic             SCANOUT_DIN,
    output logic [NCH-1:0]   MEAS_STRESS,
    output logic [NCH-1:0]   EN_ROSC,
    output logic             BUSY,
    output logic             DONE,
    output logic             SCANOUT_DOUT
);

    localparam int unsigned F   = 2 * CW + 1;
    localparam int unsigned RW  = NCH * F;
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SW  = $clog2(SETTLE + 1);
    localparam int unsigned TW  = (WIN_W > SW) ? WIN_W : SW;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_COUNT  = 3'd2;
    localparam logic [2:0] S_STORE  = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CW-1:0]    str_cnt_q, str_cnt_d;
    logic [CW-1:0]    ref_cnt_q, ref_cnt_d;
    logic             sat_q, sat_d;
    logic [RW-1:0]    res_q, res_d;
    logic [NCH-1:0]   onehot_q, onehot_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Trigger detector stores "last sample was low"; reset to 0 so a level
    // held high through reset release cannot fire a sweep.
    logic             trig_low_q;
    logic             trig_edge;

    logic [NCH-1:0]   str_s1_q, str_s2_q, str_p_q;
    logic [NCH-1:0]   ref_s1_q, ref_s2_q, ref_p_q;
    logic [NCH-1:0]   str_edge, ref_edge;

    logic [CHW:0]     first_ch, next_ch;

    // Lowest set mask bit at or above lo; MSB of result flags "found".
    function automatic logic [CHW:0] find_from(input logic [NCH-1:0] m, input int lo);
        logic [CHW:0] r;
        r = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (i >= lo && m[i]) r = {1'b1, CHW'(i)};
        end
        return r;
    endfunction

    assign trig_edge = MEAS_TRIG & trig_low_q;
    assign str_edge  = str_s2_q & ~str_p_q;
    assign ref_edge  = ref_s2_q & ~ref_p_q;
    assign first_ch  = find_from(CH_MASK, 0);
    assign next_ch   = find_from(mask_q, int'(ch_q) + 1);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        mask_d    = mask_q;
        win_d     = win_q;
        tmr_d     = tmr_q;
        str_cnt_d = str_cnt_q;
        ref_cnt_d = ref_cnt_q;
        sat_d     = sat_q;
        res_d     = res_q;

        case (state_q)
            S_IDLE: begin
                if (trig_edge) begin
                    mask_d = CH_MASK;
                    win_d  = (WINDOW == '0) ? WIN_W'(1) : WINDOW;
                    res_d  = '0;
                    if (first_ch[CHW]) begin
                        ch_d    = first_ch[CHW-1:0];
                        tmr_d   = TW'(SETTLE - 1);
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_FIN;
                    end
                end else if (SHIFT_EN) begin
                    res_d = {SCANOUT_DIN, res_q[RW-1:1]};
                end
            end
            S_SETTLE: begin
                str_cnt_d = '0;
                ref_cnt_d = '0;
                sat_d     = 1'b0;
                if (tmr_q == '0) begin
                    tmr_d   = TW'(win_q - WIN_W'(1));
                    state_d = S_COUNT;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_COUNT: begin
                if (str_edge[ch_q]) begin
                    if (str_cnt_q == '1) sat_d = 1'b1;
                    else                 str_cnt_d = str_cnt_q + CW'(1);
                end
                if (ref_edge[ch_q]) begin
                    if (ref_cnt_q == '1) sat_d = 1'b1;
                    else                 ref_cnt_d = ref_cnt_q + CW'(1);
                end
                if (tmr_q == '0) state_d = S_STORE;
                else             tmr_d   = tmr_q - TW'(1);
            end
            S_STORE: begin
                for (int c = 0; c < int'(NCH); c++) begin
                    if (ch_q == CHW'(c)) res_d[c*F +: F] = {sat_q, str_cnt_q, ref_cnt_q};
                end
                if (next_ch[CHW]) begin
                    ch_d    = next_ch[CHW-1:0];
                    tmr_d   = TW'(SETTLE - 1);
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d == S_SETTLE) || (state_d == S_COUNT) || (state_d == S_STORE);
        done_d   = (state_d == S_FIN);
        onehot_d = busy_d ? (NCH'(1) << ch_d) : '0;
    end

    // State, datapath, synchronisers and output registers
    always_ff @(posedge MEAS_CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            mask_q     <= '0;
            win_q      <= '0;
            tmr_q      <= '0;
            str_cnt_q  <= '0;
            ref_cnt_q  <= '0;
            sat_q      <= 1'b0;
            res_q      <= '0;
            onehot_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            trig_low_q <= 1'b0;
            str_s1_q   <= '0;
            str_s2_q   <= '0;
            str_p_q    <= '0;
            ref_s1_q   <= '0;
            ref_s2_q   <= '0;
            ref_p_q    <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            mask_q     <= mask_d;
            win_q      <= win_d;
            tmr_q      <= tmr_d;
            str_cnt_q  <= str_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            sat_q      <= sat_d;
            res_q      <= res_d;
            onehot_q   <= onehot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            trig_low_q <= ~MEAS_TRIG;
            str_s1_q   <= ROSC_STRESS_OUT;
            str_s2_q   <= str_s1_q;
            str_p_q    <= str_s2_q;
            ref_s1_q   <= ROSC_REF_OUT;
            ref_s2_q   <= ref_s1_q;
            ref_p_q    <= ref_s2_q;
        end
    end

    assign MEAS_STRESS  = onehot_q;
    assign EN_ROSC      = onehot_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign SCANOUT_DOUT = res_q[0];

endmodule
